// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALU codes, FSM states and staged-control layout for ctrl_sequencer
package ctrl_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [5:0] ALU_ADD = 6'd1;
  localparam logic [5:0] ALU_SUB = 6'd2;
  localparam logic [5:0] ALU_AND = 6'd3;
  localparam logic [5:0] ALU_OR  = 6'd4;
  localparam logic [5:0] ALU_XOR = 6'd5;
  localparam logic [5:0] ALU_SLL = 6'd6;
  localparam logic [5:0] ALU_SRL = 6'd7;
  localparam logic [5:0] ALU_SLT = 6'd8;
  localparam logic [5:0] ALU_EQ  = 6'd9;
  localparam logic [5:0] ALU_NE  = 6'd10;
  localparam logic [5:0] ALU_LT  = 6'd11;
  localparam logic [5:0] ALU_GE  = 6'd12;
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [5:0]  alu;
    logic        alu_src;
    logic [31:0] imm;
    logic [3:0]  sh_amt;
    logic [31:0] imm_lui;
    logic        lb;
    logic        sw;
    logic        lui;
    logic        jump;
    logic        beq;
    logic        bne;
    logic        blt;
    logic        bge;
  } ctl_t;
  function automatic logic [5:0] alu_of(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: instruction fetch request/valid handshake
interface ctrl_sequencer_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_valid;
  logic [31:0] instr_data;
  modport master (output instr_req, instr_addr, input instr_valid, instr_data);
  modport slave (input instr_req, instr_addr, output instr_valid, instr_data);
endinterface

// File: rtl/imm_gen.sv
// imm_gen: I/S/B/U/J immediate extraction from the instruction register
module imm_gen (
  input  logic [31:0] ir,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_u,
  output logic [31:0] imm_j
);
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle RV32 fetch/decode sequencer; CTRL_TRAP_ILLEGAL_EN halts on illegal instructions
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  ctrl_sequencer_if.master   imem,
  output logic [4:0]         read_reg_num1,
  output logic [4:0]         read_reg_num2,
  output logic [4:0]         write_reg_num1,
  output logic [5:0]         alu_control,
  output logic               alu_src,
  output logic [31:0]        imm_val,
  output logic [3:0]         sh_amt,
  output logic [31:0]        imm_val_lui,
  output logic               lb,
  output logic               sw,
  output logic               lui_control,
  output logic               jump,
  output logic               beq_control,
  output logic               bne_control,
  output logic               blt_control,
  output logic               bgeq_control,
  output logic [31:0]        pc_out,
  input  logic               beq,
  input  logic               bneq,
  input  logic               bge,
  input  logic               blt,
  output logic               halt,
  output logic               illegal
);
  state_t state, state_n;
  logic [31:0] pc, ir, step;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic started, bad, stop, trap, taken;
  ctl_t raw, dec, ctl, o;
  logic [6:0] op, f7;
  logic [2:0] f3;
  imm_gen u_imm (.ir(ir), .imm_i(imm_i), .imm_s(imm_s), .imm_b(imm_b), .imm_u(imm_u), .imm_j(imm_j));
  assign op = ir[6:0];
  assign f3 = ir[14:12];
  assign f7 = ir[31:25];
  always_comb begin
    raw = '0;
    bad = 1'b0;
    stop = 1'b0;
    raw.sh_amt = ir[23:20];
    raw.imm_lui = imm_u;
    case (op)
      OP_R: begin
        raw.rs1 = ir[19:15];
        raw.rs2 = ir[24:20];
        raw.rd = ir[11:7];
        raw.alu = alu_of(f3, f7[5]);
        bad = !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'b000)) || raw.alu == '0;
      end
      OP_I: begin
        raw.rs1 = ir[19:15];
        raw.rd = ir[11:7];
        raw.alu = alu_of(f3, 1'b0);
        raw.alu_src = 1'b1;
        raw.imm = imm_i;
        bad = raw.alu == '0 || (f3[1:0] == 2'b01 && f7 != 7'h00);
      end
      OP_LOAD: begin
        raw.rs1 = ir[19:15];
        raw.rd = ir[11:7];
        raw.alu = ALU_ADD;
        raw.alu_src = 1'b1;
        raw.imm = imm_i;
        raw.lb = 1'b1;
        bad = f3 != 3'b000;
      end
      OP_STORE: begin
        raw.rs1 = ir[19:15];
        raw.rs2 = ir[24:20];
        raw.alu = ALU_ADD;
        raw.alu_src = 1'b1;
        raw.imm = imm_s;
        raw.sw = 1'b1;
        bad = f3 != 3'b010;
      end
      OP_BRANCH: begin
        raw.rs1 = ir[19:15];
        raw.rs2 = ir[24:20];
        raw.imm = imm_b;
        raw.beq = f3 == 3'b000;
        raw.bne = f3 == 3'b001;
        raw.blt = f3 == 3'b100;
        raw.bge = f3 == 3'b101;
        raw.alu = raw.beq ? ALU_EQ : raw.bne ? ALU_NE : raw.blt ? ALU_LT : raw.bge ? ALU_GE : '0;
        bad = raw.alu == '0;
      end
      OP_LUI: begin
        raw.rd = ir[11:7];
        raw.lui = 1'b1;
      end
      OP_JAL: begin
        raw.rd = ir[11:7];
        raw.jump = 1'b1;
      end
      OP_SYS:  stop = 1'b1;
      default: bad = 1'b1;
    endcase
  end
  // an undecodable word stages an all-zero NOP
  assign dec = bad ? '0 : raw;
`ifdef CTRL_TRAP_ILLEGAL_EN
  assign trap = bad;
  always_ff @(posedge clk or negedge rst)
    if (!rst) illegal <= 1'b0;
    else if (state == DECODE && bad) illegal <= 1'b1;
`else
  assign trap = 1'b0;
  assign illegal = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      FETCH:   state_n = started && imem.instr_valid ? DECODE : FETCH;
      DECODE:  state_n = stop || trap ? HALT : EXEC;
      EXEC:    state_n = FETCH;
      default: state_n = HALT;
    endcase
  end
  assign taken = (ctl.beq & beq) | (ctl.bne & bneq) | (ctl.blt & blt) | (ctl.bge & bge);
  assign step = ctl.jump ? imm_j : taken ? imm_b : 32'd4;
  // started keeps the request low during the first cycle out of reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      ir <= '0;
      ctl <= '0;
      started <= 1'b0;
    end else begin
      state <= state_n;
      started <= 1'b1;
      if (state == FETCH && started && imem.instr_valid) ir <= imem.instr_data;
      if (state == DECODE) ctl <= dec;
      if (state == EXEC) pc <= (pc + step) & ~32'h3;
    end
  assign o = state == EXEC ? ctl : '0;
  assign read_reg_num1 = o.rs1;
  assign read_reg_num2 = o.rs2;
  assign write_reg_num1 = o.rd;
  assign alu_control = o.alu;
  assign alu_src = o.alu_src;
  assign imm_val = o.imm;
  assign sh_amt = o.sh_amt;
  assign imm_val_lui = o.imm_lui;
  assign lb = o.lb;
  assign sw = o.sw;
  assign lui_control = o.lui;
  assign jump = o.jump;
  assign beq_control = o.beq;
  assign bne_control = o.bne;
  assign blt_control = o.blt;
  assign bgeq_control = o.bge;
  assign pc_out = state == EXEC ? pc : '0;
  assign halt = state == HALT;
  assign imem.instr_req = started && state == FETCH;
  assign imem.instr_addr = imem.instr_req ? pc : '0;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed scoreboard bench for ctrl_sequencer
module tb_ctrl_sequencer;
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [5:0]  alu;
    logic        src;
    logic [31:0] imm;
    logic [3:0]  sh;
    logic [31:0] lui;
    logic [7:0]  st;
    logic [31:0] pc;
  } obs_t;
  typedef struct packed {
    obs_t        o;
    logic [31:0] nxt;
  } sb_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic beq = 1'b0, bneq = 1'b0, bge = 1'b0, blt = 1'b0;
  logic [4:0] read_reg_num1, read_reg_num2, write_reg_num1;
  logic [5:0] alu_control;
  logic alu_src, lb, sw, lui_control, jump, beq_control, bne_control, blt_control, bgeq_control, halt, illegal;
  logic [31:0] imm_val, imm_val_lui, pc_out;
  logic [3:0] sh_amt;
  ctrl_sequencer_if bus ();
  ctrl_sequencer dut (
    .clk(clk), .rst(rst), .imem(bus),
    .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2), .write_reg_num1(write_reg_num1),
    .alu_control(alu_control), .alu_src(alu_src), .imm_val(imm_val), .sh_amt(sh_amt),
    .imm_val_lui(imm_val_lui), .lb(lb), .sw(sw), .lui_control(lui_control), .jump(jump),
    .beq_control(beq_control), .bne_control(bne_control), .blt_control(blt_control),
    .bgeq_control(bgeq_control), .pc_out(pc_out), .beq(beq), .bneq(bneq), .bge(bge), .blt(blt),
    .halt(halt), .illegal(illegal)
  );
  always #5 clk = ~clk;
  sb_t sb[$];
  int passed = 0, total = 0, fails = 0;
  logic [31:0] cur_pc = 32'h0;
  function automatic obs_t get_obs();
    return {read_reg_num1, read_reg_num2, write_reg_num1, alu_control, alu_src, imm_val, sh_amt, imm_val_lui,
            lb, sw, lui_control, jump, beq_control, bne_control, blt_control, bgeq_control, pc_out};
  endfunction
  function automatic sb_t mk(input logic [4:0] rs1, rs2, rd, input logic [5:0] alu, input logic src,
                             input logic [31:0] imm, input logic [3:0] sh, input logic [31:0] lui,
                             input logic [7:0] st, input logic [31:0] pc, nxt);
    return {rs1, rs2, rd, alu, src, imm, sh, lui, st, pc, nxt};
  endfunction
  task automatic chk_obs(input string tag, input obs_t got, input obs_t exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic wait_req();
    int n = 0;
    while (bus.instr_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk32("fetch_req", {31'd0, bus.instr_req}, 32'd1);
    chk32("fetch_addr", bus.instr_addr, cur_pc);
  endtask
  task automatic run(input logic [31:0] word, input int waits, input logic [3:0] flags, input sb_t e);
    sb_t x;
    obs_t ob;
    wait_req();
    repeat (waits) @(negedge clk);
    chk32("req_held", {31'd0, bus.instr_req}, 32'd1);
    bus.instr_valid = 1'b1;
    bus.instr_data = word;
    sb.push_back(e);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk_obs("decode_idle", get_obs(), '0);
    @(negedge clk);
    {beq, bneq, blt, bge} = flags;
    x = sb.pop_front();
    chk_obs("exec", get_obs(), x.o);
    @(negedge clk);
    {beq, bneq, blt, bge} = 4'b0;
    ob = get_obs();
    chk32("strobe_width", {24'd0, ob.st}, 32'd0);
    cur_pc = x.nxt;
  endtask
  task automatic run_halt(input logic [31:0] word, input logic ill);
    wait_req();
    bus.instr_valid = 1'b1;
    bus.instr_data = word;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk32("halt_enter", {29'd0, halt, illegal, bus.instr_req}, {29'd0, 1'b1, ill, 1'b0});
    repeat (3) @(negedge clk);
    chk32("halt_hold", {29'd0, halt, illegal, bus.instr_req}, {29'd0, 1'b1, ill, 1'b0});
  endtask
  initial begin
    sb_t addi_e;
    addi_e = mk(5'd0, 5'd0, 5'd1, 6'd1, 1'b1, 32'd5, 4'd5, 32'h0050_0000, 8'h00, 32'h0, 32'h4);
    bus.instr_valid = 1'b0;
    bus.instr_data = '0;
    repeat (3) @(negedge clk);
    chk_obs("reset_ctl", get_obs(), '0);
    chk32("reset_status", {29'd0, bus.instr_req, halt, illegal}, 32'd0);
    chk32("reset_addr", bus.instr_addr, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk32("first_req", {31'd0, bus.instr_req}, 32'd1);
    run(32'h0050_0093, 3, 4'b0000, addi_e);
    run(32'h4020_81B3, 0, 4'b0000, mk(5'd1, 5'd2, 5'd3, 6'd2, 1'b0, 32'd0, 4'd2, 32'h4020_8000, 8'h00, 32'h4, 32'h8));
    run(32'hFE20_8CE3, 1, 4'b1000, mk(5'd1, 5'd2, 5'd0, 6'd9, 1'b0, 32'hFFFF_FFF8, 4'd2, 32'hFE20_8000, 8'h08, 32'h8, 32'h0));
    run(32'h0050_0093, 0, 4'b0000, addi_e);
    run(32'h4020_81B3, 0, 4'b0000, mk(5'd1, 5'd2, 5'd3, 6'd2, 1'b0, 32'd0, 4'd2, 32'h4020_8000, 8'h00, 32'h4, 32'h8));
    run(32'hFE20_8CE3, 0, 4'b0111, mk(5'd1, 5'd2, 5'd0, 6'd9, 1'b0, 32'hFFFF_FFF8, 4'd2, 32'hFE20_8000, 8'h08, 32'h8, 32'hC));
    run(32'h0020_A223, 2, 4'b1111, mk(5'd1, 5'd2, 5'd0, 6'd1, 1'b1, 32'd4, 4'd2, 32'h0020_A000, 8'h40, 32'hC, 32'h10));
    run(32'h0100_00EF, 0, 4'b0000, mk(5'd0, 5'd0, 5'd1, 6'd0, 1'b0, 32'd0, 4'd0, 32'h0100_0000, 8'h10, 32'h10, 32'h20));
    run(32'h1234_52B7, 0, 4'b0000, mk(5'd0, 5'd0, 5'd5, 6'd0, 1'b0, 32'd0, 4'd3, 32'h1234_5000, 8'h20, 32'h20, 32'h24));
`ifdef CTRL_TRAP_ILLEGAL_EN
    run_halt(32'hFFFF_FFFF, 1'b1);
`else
    run(32'hFFFF_FFFF, 0, 4'b0000, mk(5'd0, 5'd0, 5'd0, 6'd0, 1'b0, 32'd0, 4'd0, 32'd0, 8'h00, 32'h24, 32'h28));
    run_halt(32'h0000_0073, 1'b0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk32("rereset_status", {29'd0, bus.instr_req, halt, illegal}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    cur_pc = 32'h0;
    run(32'h0050_0093, 0, 4'b0000, addi_e);
    chk32("pre_reset_addr", bus.instr_addr, 32'h4);
    rst = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instr_data = 32'h0000_0073;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk32("rst_mid_fetch_addr", bus.instr_addr, 32'h0);
    @(negedge clk);
    chk32("late_valid_ignored", {30'd0, halt, bus.instr_req}, 32'd1);
    cur_pc = 32'h0;
    run(32'h0050_0093, 1, 4'b0000, addi_e);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
